// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, instruction opcodes and the issue FSM states.
// Used by the issue controller, its decode table and the ALU datapath.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_MUL = 3'd2;
    localparam logic [2:0] ALU_SHL = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_NOT = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    localparam int OPC_RTYPE = 0;
    localparam int OPC_ADDI  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_MC   = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_decode.sv
// Pure combinational decode of (opcode, func) into the ALU control word.
// Anything not recognised is flagged illegal and takes the single-cycle path.
module alu_decode
    import alu_pkg::*;
#(
    parameter int OP_W   = 3,
    parameter int FN_W   = 4,
    parameter int CODE_W = 3
) (
    input  logic [OP_W-1:0]   opcode,
    input  logic [FN_W-1:0]   func,
    output logic [CODE_W-1:0] alu_code,
    output logic              src_imm,
    output logic              illegal,
    output logic              is_mul
);

    logic [31:0] opcode_ext;
    logic [31:0] func_ext;

    assign opcode_ext = 32'(opcode);
    assign func_ext   = 32'(func);

    always_comb begin
        alu_code = '0;
        src_imm  = 1'b0;
        illegal  = 1'b0;
        is_mul   = 1'b0;
        if (opcode_ext == 32'(OPC_ADDI)) begin
            alu_code = CODE_W'(ALU_ADD);
            src_imm  = 1'b1;
        end else if (opcode_ext == 32'(OPC_RTYPE)) begin
            case (func_ext)
                32'd0:   alu_code = CODE_W'(ALU_ADD);
                32'd1:   alu_code = CODE_W'(ALU_SUB);
                32'd2: begin
                    alu_code = CODE_W'(ALU_MUL);
                    is_mul   = 1'b1;
                end
                32'd3:   alu_code = CODE_W'(ALU_SHL);
                32'd4:   alu_code = CODE_W'(ALU_AND);
                32'd5:   alu_code = CODE_W'(ALU_OR);
                32'd6:   alu_code = CODE_W'(ALU_NOT);
                32'd7:   alu_code = CODE_W'(ALU_XOR);
                default: illegal  = 1'b1;
            endcase
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts an instruction, registers its decoded control word and
// presents it downstream, stretching multiplies over MUL_CYCLES clocks.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int OP_W       = 3,
    parameter int FN_W       = 4,
    parameter int CODE_W     = 3,
    parameter int MUL_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   opcode,
    input  logic [FN_W-1:0]   func,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] alu_code,
    output logic              src_imm,
    output logic              illegal,
    output logic              busy
);

    localparam int CNT_W = $clog2(MUL_CYCLES);

    issue_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CODE_W-1:0]  alu_code_q, alu_code_d;
    logic               src_imm_q, src_imm_d;
    logic               illegal_q, illegal_d;

    logic [CODE_W-1:0]  dec_code;
    logic               dec_imm;
    logic               dec_illegal;
    logic               dec_is_mul;
    logic               transfer;
    logic               load;

    alu_decode #(
        .OP_W   (OP_W),
        .FN_W   (FN_W),
        .CODE_W (CODE_W)
    ) u_decode (
        .opcode   (opcode),
        .func     (func),
        .alu_code (dec_code),
        .src_imm  (dec_imm),
        .illegal  (dec_illegal),
        .is_mul   (dec_is_mul)
    );

    // A held word can be replaced in the same edge it is consumed, giving back-to-back issue.
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign transfer = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_code_d = alu_code_q;
        src_imm_d  = src_imm_q;
        illegal_d  = illegal_q;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load = transfer;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    load    = transfer;
                end
            end
            ST_MC: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            alu_code_d = dec_code;
            src_imm_d  = dec_imm;
            illegal_d  = dec_illegal;
            if (dec_is_mul) begin
                state_d = ST_MC;
                cnt_d   = CNT_W'(MUL_CYCLES - 1);
            end else begin
                state_d = ST_HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            alu_code_q <= '0;
            src_imm_q  <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_code_q <= alu_code_d;
            src_imm_q  <= src_imm_d;
            illegal_q  <= illegal_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_MC);
    assign alu_code  = alu_code_q;
    assign src_imm   = src_imm_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl against a transaction-level
// model: a held word, a multiply wait countdown and an arithmetic decode rule.
module tb_alu_issue_ctrl;

    localparam int OP_W       = 3;
    localparam int FN_W       = 4;
    localparam int CODE_W     = 3;
    localparam int MUL_CYCLES = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   opcode;
    logic [FN_W-1:0]   func;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] alu_code;
    logic              src_imm;
    logic              illegal;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    // Model: word waiting for downstream, its fields, and edges left before a multiply delivers.
    bit m_hold;
    int m_mul_wait;
    int m_code;
    bit m_imm;
    bit m_ill;

    alu_issue_ctrl #(
        .OP_W       (OP_W),
        .FN_W       (FN_W),
        .CODE_W     (CODE_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .func      (func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_code  (alu_code),
        .src_imm   (src_imm),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // R-type codes equal the func value; addi is an add with immediate; the rest is illegal.
    function automatic void refDecode(input int opc, input int fn,
                                      output int code, output bit imm,
                                      output bit ill, output bit mul);
        code = 0; imm = 0; ill = 0; mul = 0;
        if (opc == 1) begin
            imm = 1;
        end else if (opc == 0 && fn <= 7) begin
            code = fn;
            mul  = (fn == 2);
        end else begin
            ill = 1;
        end
    endfunction

    function automatic bit expInReady(input bit ordy);
        return (m_mul_wait == 0) && (!m_hold || ordy);
    endfunction

    task automatic compareAll();
        checkOutput("in_ready", 32'(in_ready), 32'(expInReady(out_ready)));
        checkOutput("out_valid", 32'(out_valid), 32'(m_hold));
        checkOutput("busy", 32'(busy), 32'(m_mul_wait > 0));
        if (m_hold) begin
            checkOutput("alu_code", 32'(alu_code), 32'(m_code));
            checkOutput("src_imm", 32'(src_imm), 32'(m_imm));
            checkOutput("illegal", 32'(illegal), 32'(m_ill));
        end
    endtask

    // One clock: drive at the falling edge, check, then advance the model over the rising edge.
    task automatic applyStimulus(input bit v, input int opc, input int fn, input bit ordy);
        bit xfer;
        int code;
        bit imm, ill, mul;
        @(negedge clk);
        in_valid  = v;
        opcode    = OP_W'(opc);
        func      = FN_W'(fn);
        out_ready = ordy;
        #1;
        compareAll();
        xfer = v && expInReady(ordy);
        if (m_mul_wait > 0) begin
            m_mul_wait--;
            if (m_mul_wait == 0) m_hold = 1;
        end else if (m_hold && ordy) begin
            m_hold = 0;
        end
        if (xfer) begin
            refDecode(opc, fn, code, imm, ill, mul);
            m_code = code;
            m_imm  = imm;
            m_ill  = ill;
            if (mul) begin
                m_mul_wait = MUL_CYCLES;
                m_hold     = 0;
            end else begin
                m_hold = 1;
            end
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_alu_code", 32'(alu_code), 32'd0);
        checkOutput("rst_src_imm", 32'(src_imm), 32'd0);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);
        m_hold     = 0;
        m_mul_wait = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit v, ordy;
        int opc, fn;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        opcode    = '0;
        func      = '0;
        out_ready = 1'b0;
        m_hold     = 0;
        m_mul_wait = 0;
        m_code     = 0;
        m_imm      = 0;
        m_ill      = 0;

        applyReset();

        // sub, then addi with a junk func, then an illegal opcode
        applyStimulus(1, 0, 1, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 1, 9, 1);
        applyStimulus(1, 5, 3, 1);
        applyStimulus(0, 0, 0, 1);

        // multiply occupies the block for MUL_CYCLES edges
        applyStimulus(1, 0, 2, 1);
        for (int i = 0; i < MUL_CYCLES + 2; i++) applyStimulus(1, 0, 4, 0);
        applyStimulus(0, 0, 0, 1);

        // back-to-back stream, then a three-cycle stall with changing inputs
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 4, 1);
        applyStimulus(1, 0, 7, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, i + 3, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);

        // reset while the multiply counter sits at 3; nothing may appear afterwards
        applyStimulus(1, 0, 2, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);
        applyReset();
        for (int i = 0; i < MUL_CYCLES + 2; i++) applyStimulus(0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                applyReset();
            end else begin
                v    = ($urandom_range(0, 3) != 0);
                opc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                                   : int'($urandom_range(0, 1));
                fn   = ($urandom_range(0, 5) == 0) ? 2 : int'($urandom_range(0, 15));
                ordy = ($urandom_range(0, 3) != 0);
                applyStimulus(v, opc, fn, ordy);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter OP_W, default 3, opcode width.
REQ-002 SHALL have parameter FN_W, default 4, R-type func width.
REQ-003 SHALL have parameter CODE_W, default 3, ALU operation code width (minimum 3).
REQ-004 SHALL have parameter MUL_CYCLES, default 8, multi-cycle multiply latency in clocks (legal range 2..255).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  instruction fields present.
REQ-008 SHALL have port in_ready  output  1  block accepts instruction this cycle.
REQ-009 SHALL have port opcode  input  OP_W  instruction opcode.
REQ-010 SHALL have port func  input  FN_W  R-type function field.
REQ-011 SHALL have port out_valid  output  1  decoded control word available.
REQ-012 SHALL have port out_ready  input  1  downstream ALU consumes control word.
REQ-013 SHALL have port alu_code  output  CODE_W  ALU operation select.
REQ-014 SHALL have port src_imm  output  1  ALU operand B from immediate.
REQ-015 SHALL have port illegal  output  1  accepted instruction undecodable.
REQ-016 SHALL have port busy  output  1  multi-cycle operation in progress.

Function
REQ-017 SHALL decode opcode 0 by func: 0 add->0, 1 sub->1, 2 mul->2 (multi-cycle), 3 shl->3, 4 and->4, 5 or->5, 6 not->6, 7 xor->7; src_imm=0.
REQ-018 SHALL decode opcode 1 (addi) as alu_code=0, src_imm=1, regardless of func.
REQ-019 SHALL treat any other opcode, or opcode 0 with func>7, as illegal: alu_code=0, src_imm=0, illegal=1, single-cycle path.
REQ-020 SHALL transfer an instruction on a rising edge where in_valid and in_ready are both 1; decoded fields SHALL be registered at that edge.
REQ-021 SHALL implement FSM states IDLE, HOLD, MC.
REQ-022 SHALL drive in_ready = (state==IDLE) or (state==HOLD and out_ready); combinational from out_ready, never from in_valid.
REQ-023 IDLE: on transfer of non-mul go HOLD with out_valid=1 after the same edge; on transfer of mul go MC, load counter with MUL_CYCLES-1, out_valid=0, busy=1.
REQ-024 MC: counter decrements each edge; at the edge where counter==0, go HOLD, out_valid=1, busy=0; total MUL_CYCLES edges from transfer to out_valid.
REQ-025 HOLD: outputs stable while out_ready=0; on out_ready=1 with no transfer go IDLE, out_valid=0; on out_ready=1 with simultaneous transfer, consume and accept in the same edge, next state per REQ-023 (back-to-back, no bubble).
REQ-026 SHALL ignore opcode/func whenever no transfer occurs; inputs changing in MC or stalled HOLD SHALL not alter outputs.
REQ-027 SHALL sustain one instruction per clock for non-mul streams with out_ready held 1.

Reset
REQ-028 SHALL, on rst_n low, asynchronously force state=IDLE, counter=0, out_valid=0, alu_code=0, src_imm=0, illegal=0, busy=0; in_ready=1 follows from IDLE.
REQ-029 SHALL abandon any in-flight mul or held word on reset mid-operation; no output after release until a new transfer.
REQ-030 SHALL leave reset synchronously with clk (first transfer possible on first edge after rst_n rises).

Structure
REQ-031 SHALL place ALU op-code constants, opcode constants (R-type, addi), and FSM state enum in shared package alu_pkg, used also by the ALU.
REQ-032 SHALL isolate the pure combinational decode table in one sub-module alu_decode (opcode, func -> alu_code, src_imm, illegal, is_mul).
REQ-033 SHALL size counter as clog2(MUL_CYCLES) bits.

Verification
REQ-034 Reset then opcode=0 func=1, out_ready=1 -> alu_code=1, src_imm=0, out_valid for exactly one cycle after transfer edge.
REQ-035 opcode=1 func=9 -> alu_code=0, src_imm=1, illegal=0; opcode=5 -> illegal=1, alu_code=0.
REQ-036 mul (opcode=0 func=2), MUL_CYCLES=8 -> busy=1 and in_ready=0 for 8 edges, then out_valid=1 alu_code=2, busy=0.
REQ-037 Stream add,and,xor with out_ready=1 -> codes 0,4,7 on three consecutive cycles; hold out_ready=0 for 3 cycles -> alu_code frozen, in_ready=0.
REQ-038 rst_n low during MC counter=3 -> immediately out_valid=0, busy=0, in_ready=1; no stale mul result after release.
